// File: rtl/riscv_fetch_pkg.sv
// ============================================================================
// Module   : riscv_fetch_pkg
// Brief    : Shared widths, constants and queue entry type for the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Synchronous FIFO of fetch entries with push/pop/flush; the head
//            output holds its last value while the queue is empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  fetch_entry_t     last_q, last_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = empty ? last_q : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    last_d   = head;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      last_q   <= last_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner and ROM fetch front end feeding decode through a queue.
//            Define FETCH_BOUND_CHECK_EN to fault on fetches past ROM_DEPTH.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          ROM_DEPTH   = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  output logic [XLEN-1:0] rom_addr,
  input  logic [ILEN-1:0] rom_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) || (ROM_DEPTH < 1))
  begin : g_param_check
    $error("instr_fetch_unit: QUEUE_DEPTH must be a power of two >= 2, ROM_DEPTH >= 1");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_target;
  logic            pop, push, fault_block;
  logic            q_full, q_empty;
  fetch_entry_t    push_entry, head;

  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign rom_addr        = pc_q;
  assign instr_valid     = ~q_empty;
  assign instr           = head.instr;
  assign instr_pc        = head.pc;
  assign pop             = instr_valid & instr_ready;
  assign push            = fetch_en & ~redirect_valid & ~fault_block & (~q_full | pop);
  assign push_entry      = '{instr: rom_data, pc: pc_q};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_q, fault_d;
  logic target_oor;

  assign fault_block = ({2'b00, pc_q[XLEN-1:2]} >= 32'(ROM_DEPTH));
  assign target_oor  = ({2'b00, redirect_target[XLEN-1:2]} >= 32'(ROM_DEPTH));
  assign fetch_fault = fault_q;

  // Sticky: only a redirect to an in-range target clears it.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) begin
      fault_d = fault_q & target_oor;
    end else if (fault_block & fetch_en) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign fault_block = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed vector bench for instr_fetch_unit with a behavioural ROM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] rom_addr, rom_data, instr, instr_pc;
  logic        instr_valid, fetch_fault;

  logic [31:0] rom [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr[7:2]];

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2),
    .ROM_DEPTH  (64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault)
  );

  typedef struct {
    logic        rst, fe, rdy, rv;
    logic [31:0] rpc;
    logic        ev, chk;
    logic [31:0] ipc, iw, addr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] w(input logic [31:0] a);
    return rom[a[7:2]];
  endfunction

  task automatic add(input logic rst, fe, rdy, rv, input logic [31:0] rpc,
                     input logic ev, chk, input logic [31:0] ipc, iw, addr);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.chk = chk; v.ipc = ipc; v.iw = iw; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, fe, rdy, rv, input logic [31:0] rpc);
    reset = rst; fetch_en = fe; instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    logic [31:0] exp_pc;
    int waited;

    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i;
    rom[0] = 32'h0ad00093;
    rom[1] = 32'h00800113;
    rom[2] = 32'h002091b3;
    rom[3] = 32'h00402023;

    // rst fe rdy rv rpc            | ev chk ipc          iw           addr
    add(1, 1, 1, 0, 32'h0,          0, 1, 32'h0,        32'h0,       32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h0,        w(32'h0),    32'h4);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h4,        w(32'h4),    32'h8);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h8,        w(32'h8),    32'hC);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'hC,        w(32'hC),    32'h10);
    // backpressure from reset
    add(1, 1, 1, 0, 32'h0,          0, 1, 32'h0,        32'h0,       32'h0);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0,        w(32'h0),    32'h4);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 32'h0,        1, 1, 32'h0,        w(32'h0),    32'h8);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h4,        w(32'h4),    32'hC);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h8,        w(32'h8),    32'h10);
    // redirect with full queue and a pop in the same cycle
    add(0, 1, 1, 1, 32'h23,         0, 0, 32'h0,        32'h0,       32'h20);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h20,       w(32'h20),   32'h24);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h24,       w(32'h24),   32'h28);
    // reset mid-stream with pc = 0x10, full queue and a redirect
    add(1, 1, 1, 0, 32'h0,          0, 1, 32'h0,        32'h0,       32'h0);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0,        w(32'h0),    32'h4);
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0,        w(32'h0),    32'h8);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h4,        w(32'h4),    32'hC);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h8,        w(32'h8),    32'h10);
    add(1, 1, 1, 1, 32'h40,         0, 1, 32'h0,        32'h0,       32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h0,        w(32'h0),    32'h4);
    // fetch_en low: drain, hold pc, resume
    add(0, 1, 0, 0, 32'h0,          1, 1, 32'h0,        w(32'h0),    32'h8);
    add(0, 0, 1, 0, 32'h0,          1, 1, 32'h4,        w(32'h4),    32'h8);
    add(0, 0, 1, 0, 32'h0,          0, 0, 32'h0,        32'h0,       32'h8);
    add(0, 0, 1, 0, 32'h0,          0, 0, 32'h0,        32'h0,       32'h8);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h8,        w(32'h8),    32'hC);
`ifndef FETCH_BOUND_CHECK_EN
    // pc wrap from the top of the address space
    add(0, 1, 1, 1, 32'hFFFF_FFFF,  0, 0, 32'h0,        32'h0,       32'hFFFF_FFFC);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC), 32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h0,        w(32'h0),    32'h4);
`endif
    // back-to-back redirects: last one wins
    add(0, 1, 1, 1, 32'h100,        0, 0, 32'h0,        32'h0,       32'h100);
    add(0, 1, 1, 1, 32'h8,          0, 0, 32'h0,        32'h0,       32'h8);
    add(0, 1, 1, 0, 32'h0,          1, 1, 32'h8,        w(32'h8),    32'hC);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      tick();
      check($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].ev});
      check($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].addr);
      if (vecs[i].chk) begin
        check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].ipc);
        check($sformatf("v%0d instr", i), instr, vecs[i].iw);
      end
`ifndef FETCH_BOUND_CHECK_EN
      check($sformatf("v%0d fetch_fault", i), {31'b0, fetch_fault}, 32'h0);
`endif
    end

    // Sustained stream with periodic backpressure: order and count of accepted words.
    drive(1, 1, 1, 0, 32'h0);
    tick();
    accepted = 0;
    exp_pc   = 32'h0;
    waited   = 0;
    drive(0, 1, 0, 0, 32'h0);
    while (!instr_valid && waited < 8) begin
      tick();
      waited++;
    end
    check("stream first valid", {31'b0, instr_valid}, 32'h1);
    for (int i = 1; i < 30; i++) begin
      instr_ready = (i % 4 != 3);
      #1;
      if (instr_valid && instr_ready) begin
        check($sformatf("stream pc %0d", accepted), instr_pc, exp_pc);
        check($sformatf("stream instr %0d", accepted), instr, w(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      tick();
    end
    check("stream accepted count", 32'(accepted), 32'd22);

`ifdef FETCH_BOUND_CHECK_EN
    drive(0, 1, 1, 1, 32'h0FC);
    tick();
    check("bound redirect valid", {31'b0, instr_valid}, 32'h0);
    drive(0, 1, 1, 0, 32'h0);
    tick();
    check("bound head pc", instr_pc, 32'h0FC);
    check("bound rom_addr", rom_addr, 32'h100);
    tick();
    check("bound no push", {31'b0, instr_valid}, 32'h0);
    check("bound pc held", rom_addr, 32'h100);
    check("bound fault set", {31'b0, fetch_fault}, 32'h1);
    drive(0, 1, 1, 1, 32'h0);
    tick();
    check("bound fault cleared", {31'b0, fetch_fault}, 32'h0);
    drive(0, 1, 1, 0, 32'h0);
    tick();
    check("bound restart valid", {31'b0, instr_valid}, 32'h1);
    check("bound restart pc", instr_pc, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
